// File: rtl/av_frame_ctrl.sv
// Serial frame receiver: start-bit detect, DATA_W data bits MSB first at BIT_CYCLES clocks
// per bit, stop-bit check, and a valid/ready output word with framing and overrun pulses.
//
// state | meaning
// IDLE  | waiting for a 0->1 transition on iSignal
// DATA  | sampling data bits at the end of each bit period
// STOP  | sampling the stop bit, then deliver, drop or flag the frame
module av_frame_ctrl #(
   parameter int DATA_W     = 8,
   parameter int BIT_CYCLES = 1
) (
   input  logic              iClk,
   input  logic              iReset,
   input  logic              iSignal,
   input  logic              iReady,
   output logic [DATA_W-1:0] oVector,
   output logic              oValid,
   output logic              oBusy,
   output logic              oFrameErr,
   output logic              oOverrun
);

   localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
   localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   typedef enum logic [1:0] {IDLE, DATA, STOP} state_t;

   state_t            state;
   logic              prev;
   logic [DATA_W-1:0] shiftReg;
   logic [BW-1:0]     bitCnt;
   logic [CW-1:0]     cycCnt;
   logic              cycLast;
   logic              bitLast;

   assign cycLast = (cycCnt == CW'(BIT_CYCLES - 1));
   assign bitLast = (bitCnt == BW'(DATA_W - 1));

   always_ff @(posedge iClk) begin
      if (iReset) begin
         state     <= IDLE;
         prev      <= 1'b1;
         shiftReg  <= '0;
         bitCnt    <= '0;
         cycCnt    <= '0;
         oVector   <= '0;
         oValid    <= 1'b0;
         oBusy     <= 1'b0;
         oFrameErr <= 1'b0;
         oOverrun  <= 1'b0;
      end else begin
         prev      <= iSignal;
         oFrameErr <= 1'b0;
         oOverrun  <= 1'b0;
         // a load in STOP below overrides this clear at the same edge
         if (oValid && iReady)
            oValid <= 1'b0;

         case (state)
            IDLE: begin
               if (iSignal && !prev) begin
                  state  <= DATA;
                  cycCnt <= '0;
                  bitCnt <= '0;
                  oBusy  <= 1'b1;
               end
            end
            DATA: begin
               if (cycLast) begin
                  cycCnt   <= '0;
                  shiftReg <= (shiftReg << 1) | DATA_W'(iSignal);
                  if (bitLast) begin
                     bitCnt <= '0;
                     state  <= STOP;
                  end else begin
                     bitCnt <= bitCnt + 1'b1;
                  end
               end else begin
                  cycCnt <= cycCnt + 1'b1;
               end
            end
            STOP: begin
               if (cycLast) begin
                  cycCnt <= '0;
                  state  <= IDLE;
                  oBusy  <= 1'b0;
                  if (iSignal) begin
                     oFrameErr <= 1'b1;
                  end else if (!oValid || iReady) begin
                     oVector <= shiftReg;
                     oValid  <= 1'b1;
                  end else begin
                     oOverrun <= 1'b1;
                  end
               end else begin
                  cycCnt <= cycCnt + 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               oBusy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_av_frame_ctrl.sv
// Bench for av_frame_ctrl: a per-cycle vector table on a BIT_CYCLES=1 instance, plus
// hand sequences for reset mid-frame and a BIT_CYCLES=4 instance.
module tb_av_frame_ctrl;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst1, sig1, rdy1;
   logic [7:0] vec1;
   logic       val1, busy1, fe1, ov1;

   logic       rst4, sig4, rdy4;
   logic [7:0] vec4;
   logic       val4, busy4, fe4, ov4;

   av_frame_ctrl #(.DATA_W(8), .BIT_CYCLES(1)) dut1 (
      .iClk(clk), .iReset(rst1), .iSignal(sig1), .iReady(rdy1),
      .oVector(vec1), .oValid(val1), .oBusy(busy1), .oFrameErr(fe1), .oOverrun(ov1)
   );

   av_frame_ctrl #(.DATA_W(8), .BIT_CYCLES(4)) dut4 (
      .iClk(clk), .iReset(rst4), .iSignal(sig4), .iReady(rdy4),
      .oVector(vec4), .oValid(val4), .oBusy(busy4), .oFrameErr(fe4), .oOverrun(ov4)
   );

   typedef struct {
      logic       sig;
      logic       rdy;
      logic       eValid;
      logic       eBusy;
      logic [7:0] eVec;
      logic       eFe;
      logic       eOv;
   } vec_t;

   vec_t vecs[$];
   int   nChecks = 0;
   int   nPass   = 0;

   task automatic chk(input string name,
                      input logic [7:0] aVec, input logic aV, input logic aB, input logic aF, input logic aO,
                      input logic [7:0] eVec, input logic eV, input logic eB, input logic eF, input logic eO);
      nChecks++;
      if (aVec === eVec && aV === eV && aB === eB && aF === eF && aO === eO) begin
         nPass++;
      end else begin
         $display("FAIL %s: got vec=%h valid=%b busy=%b ferr=%b ovr=%b, want vec=%h valid=%b busy=%b ferr=%b ovr=%b",
                  name, aVec, aV, aB, aF, aO, eVec, eV, eB, eF, eO);
      end
   endtask

   task automatic step1(input logic s, input logic r);
      sig1 = s;
      rdy1 = r;
      @(posedge clk);
      #1;
   endtask

   task automatic step4(input logic s, input logic r);
      sig4 = s;
      rdy4 = r;
      @(posedge clk);
      #1;
   endtask

   task automatic addv(input logic s, input logic r, input logic v, input logic b,
                       input logic [7:0] d, input logic fe, input logic ov);
      vec_t t;
      t.sig = s; t.rdy = r; t.eValid = v; t.eBusy = b; t.eVec = d; t.eFe = fe; t.eOv = ov;
      vecs.push_back(t);
   endtask

   // start bit, 8 data bits, stop bit; curV/curD are the outputs expected to hold during the frame
   task automatic addFrame(input logic [7:0] data, input logic stopBit, input logic rdyStop,
                           input logic curV, input logic [7:0] curD,
                           input logic eV, input logic [7:0] eD, input logic fe, input logic ov);
      addv(1'b1, 1'b0, curV, 1'b1, curD, 1'b0, 1'b0);
      for (int i = 7; i >= 0; i--)
         addv(data[i], 1'b0, curV, 1'b1, curD, 1'b0, 1'b0);
      addv(stopBit, rdyStop, eV, 1'b0, eD, fe, ov);
   endtask

   // BIT_CYCLES=4 frame; with glitch set, the line carries the inverse bit except on sample edges
   task automatic send4(input logic [7:0] d, input logic glitch, input logic expV, input logic [7:0] expD);
      logic bitv;
      logic s;
      step4(1'b1, 1'b0);
      chk("slow start", vec4, val4, busy4, fe4, ov4, expD, expV, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 9; i++) begin
         bitv = (i < 8) ? d[7-i] : 1'b0;
         for (int c = 0; c < 4; c++) begin
            s = (glitch && c < 3) ? ~bitv : bitv;
            step4(s, (i == 8 && c == 3));
            if (!(i == 8 && c == 3))
               chk($sformatf("slow bit%0d cyc%0d", i, c), vec4, val4, busy4, fe4, ov4,
                   expD, expV, 1'b1, 1'b0, 1'b0);
         end
      end
   endtask

   initial begin
      rst1 = 1'b1; sig1 = 1'b1; rdy1 = 1'b0;
      rst4 = 1'b1; sig4 = 1'b0; rdy4 = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset state", vec1, val1, busy1, fe1, ov1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      rst1 = 1'b0;

      // line already high out of reset is not a start
      addv(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      addv(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      addFrame(8'hBC, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'hBC, 1'b0, 1'b0);
      repeat (5) addv(1'b0, 1'b0, 1'b1, 1'b0, 8'hBC, 1'b0, 1'b0);
      addv(1'b0, 1'b1, 1'b0, 1'b0, 8'hBC, 1'b0, 1'b0);
      addv(1'b0, 1'b0, 1'b0, 1'b0, 8'hBC, 1'b0, 1'b0);
      // back-to-back frames, consumer stalled: second one overruns
      addFrame(8'hBC, 1'b0, 1'b0, 1'b0, 8'hBC, 1'b1, 8'hBC, 1'b0, 1'b0);
      addFrame(8'h3C, 1'b0, 1'b0, 1'b1, 8'hBC, 1'b1, 8'hBC, 1'b0, 1'b1);
      addv(1'b0, 1'b0, 1'b1, 1'b0, 8'hBC, 1'b0, 1'b0);
      // accept coincides with the stop edge: new word replaces old, no overrun
      addFrame(8'h3C, 1'b0, 1'b1, 1'b1, 8'hBC, 1'b1, 8'h3C, 1'b0, 1'b0);
      addv(1'b0, 1'b0, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b0);
      // framing error, then line stuck high: no restart
      addFrame(8'hA5, 1'b1, 1'b0, 1'b1, 8'h3C, 1'b1, 8'h3C, 1'b1, 1'b0);
      repeat (10) addv(1'b1, 1'b0, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b0);
      addv(1'b0, 1'b0, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b0);
      addFrame(8'h0F, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b1, 8'h3C, 1'b0, 1'b1);
      addv(1'b0, 1'b0, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b0);

      foreach (vecs[j]) begin
         step1(vecs[j].sig, vecs[j].rdy);
         chk($sformatf("vector %0d", j), vec1, val1, busy1, fe1, ov1,
             vecs[j].eVec, vecs[j].eValid, vecs[j].eBusy, vecs[j].eFe, vecs[j].eOv);
      end

      // reset after data bit 3, line held high through and after reset
      step1(1'b1, 1'b0);
      chk("rst frame start", vec1, val1, busy1, fe1, ov1, 8'h3C, 1'b1, 1'b1, 1'b0, 1'b0);
      step1(1'b1, 1'b0);
      step1(1'b0, 1'b0);
      step1(1'b1, 1'b0);
      step1(1'b1, 1'b0);
      rst1 = 1'b1;
      step1(1'b1, 1'b0);
      chk("mid-frame reset", vec1, val1, busy1, fe1, ov1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      rst1 = 1'b0;
      for (int i = 0; i < 12; i++) begin
         step1(1'b1, 1'b0);
         chk($sformatf("post-reset high %0d", i), vec1, val1, busy1, fe1, ov1,
             8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      end
      step1(1'b0, 1'b0);
      step1(1'b1, 1'b0);
      chk("post-reset start", vec1, val1, busy1, fe1, ov1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
      for (int i = 7; i >= 0; i--) begin
         logic [7:0] d;
         d = 8'h3C;
         step1(d[i], 1'b0);
      end
      chk("post-reset last bit", vec1, val1, busy1, fe1, ov1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
      step1(1'b0, 1'b0);
      chk("post-reset frame", vec1, val1, busy1, fe1, ov1, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0);

      // slow bit rate instance
      rst4 = 1'b0;
      step4(1'b0, 1'b0);
      step4(1'b0, 1'b0);
      send4(8'hA5, 1'b0, 1'b0, 8'h00);
      chk("slow frame A5", vec4, val4, busy4, fe4, ov4, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
      step4(1'b0, 1'b0);
      chk("slow idle", vec4, val4, busy4, fe4, ov4, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
      send4(8'h5A, 1'b1, 1'b1, 8'hA5);
      chk("slow glitch frame 5A", vec4, val4, busy4, fe4, ov4, 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule

// File: doc/av_frame_ctrl.md
# av_frame_ctrl

Receive controller for the serial-to-vector path: watches the single-bit line `iSignal` and detects a start bit. It then sequences the capture of `DATA_W` data bits at a programmable bit rate and checks the stop bit. Each good frame is presented as a parallel word under a valid/ready handshake. It sits between the raw serial input and any consumer of 8-bit vectors, and flags framing and overrun faults.

## Interface
- `DATA_W`, default 8: data bits per frame; `oVector` width.
- `BIT_CYCLES`, default 1: clock cycles per serial bit. Legal values are ≥1. Counter width is clog2(BIT_CYCLES), minimum 1.
- `iClk` in 1: single clock; all logic is on its rising edge.
- `iReset` in 1: synchronous, active-high reset.
- `iSignal` in 1: serial line. Idle level 0, start bit 1, stop bit 0.
- `iReady` in 1: consumer accepts `oVector` when it is high in a cycle where `oValid` is high.
- `oVector` out DATA_W: last accepted frame. The first received data bit is the MSB.
- `oValid` out 1: `oVector` holds an unconsumed frame.
- `oBusy` out 1: high while a frame is being received (states DATA and STOP).
- `oFrameErr` out 1: one-cycle pulse when a stop bit is sampled as 1.
- `oOverrun` out 1: one-cycle pulse when a good frame is dropped because `oValid` was still high.

## Operation
- Internal registers:
  - `prev`: the registered `iSignal`. Resets to 1, so a line held high at reset is not a start.
  - Shift register, width DATA_W.
  - Bit counter, 0..DATA_W-1.
  - Cycle counter, 0..BIT_CYCLES-1.
- FSM states are IDLE, DATA and STOP. Reset forces IDLE.
- IDLE: start is detected when `iSignal`=1 and `prev`=0. On start, go to DATA with both counters cleared.
- DATA:
  - The cycle counter increments each clock.
  - When it reaches BIT_CYCLES-1, sample `iSignal` into the shift register LSB (shift left) and clear the cycle counter.
  - Increment the bit counter. After bit DATA_W-1 is sampled, go to STOP.
- STOP: sample `iSignal` on cycle-counter value BIT_CYCLES-1, then go to IDLE.
  - Stop = 0 and (`oValid`=0, or `iReady`=1 this cycle): load `oVector` from the shift register and set `oValid`=1.
  - Stop = 0 and `oValid`=1 and `iReady`=0: keep the old `oVector` and `oValid`, drop the new frame, pulse `oOverrun`.
  - Stop = 1: pulse `oFrameErr`, drop the frame, leave `oVector` and `oValid` unchanged. A new start then requires the line to return to 0 and rise again.
- Handshake: `oValid`&`iReady` at an edge clears `oValid` at that edge, unless a new frame loads at the same edge. In that case `oValid` stays 1 and `oVector` updates.
- `iSignal` is not examined in DATA or STOP except at sample points. Glitches between sample points are ignored.
- `iReady` while `oValid`=0 has no effect.

## Timing
- Reset values: `oVector`=0, `oValid`=0, `oBusy`=0, `oFrameErr`=0, `oOverrun`=0, state IDLE, counters 0, `prev`=1.
- Reset asserted mid-frame: the partial frame is discarded at the next edge. No error or overrun pulse is generated.
- Let the start be detected at edge k. Then:
  - Data bit i (i=0..DATA_W-1) is sampled at edge k+(i+1)·BIT_CYCLES.
  - The stop bit is sampled at edge k+(DATA_W+1)·BIT_CYCLES.
  - `oValid`, `oFrameErr` and `oOverrun` become visible after that edge.
- `oBusy` is 1 from after edge k up to and including the stop-sample edge. It is 0 after that edge.
- Back-to-back frames: with stop=0, `prev`=0 after the stop edge. A start can be detected at the very next edge, with zero idle gap.
- All outputs are registered. There is no combinational path from an input to an output.
- Latency from the stop-bit sample to `oValid` is 0 cycles, registered at the same edge.

## Test plan
- **Good frame (DATA_W=8, BIT_CYCLES=1).**
  - Stimulus: after reset, `iSignal` sequence 0,1 | 1,0,1,1,1,1,0,0 | 0.
  - Required response: `oVector`=8'hBC and `oValid`=1 after edge k+9. `oBusy` is high for exactly 9 cycles.
- **Handshake.**
  - Stimulus: hold `iReady`=0 for 5 cycles after `oValid`, then pulse it for one cycle.
  - Required response: `oValid` stays 1 and `oVector` stays 8'hBC throughout. `oValid` drops at the edge where `iReady` is sampled.
- **Overrun and simultaneous accept.**
  - Stimulus: send two back-to-back frames, 8'hBC then 8'h3C, with `iReady`=0.
  - Required response: `oOverrun` pulses once at the second stop edge, and `oVector` stays 8'hBC.
  - Stimulus: repeat with `iReady`=1 at the second stop edge.
  - Required response: `oVector`=8'h3C, `oValid` stays 1, and no overrun pulse.
- **Framing error.**
  - Stimulus: send a frame with stop bit 1, then hold the line at 1 for 10 cycles.
  - Required response: a single `oFrameErr` pulse, `oValid` unchanged, and no new start until the line goes 0 then 1.
- **Slow bit rate (BIT_CYCLES=4).**
  - Stimulus: the frame 8'hA5 with each bit held for 4 cycles.
  - Required response: samples land at edges k+4·n, and `oValid` rises after edge k+36 with `oVector`=8'hA5.
- **Reset mid-frame.**
  - Stimulus: assert `iReset` for 1 cycle after bit 3 of a frame, with the line held at 1 through reset.
  - Required response: all outputs go to 0, and no start is detected until a fresh 0→1 transition on the line.
  - Stimulus: send a subsequent good frame.
  - Required response: it is received correctly.
